gpr_ctx_xfer: RTL and testbench
===============================

// Module: gpr_ctx_xfer
// PURPOSE
//  Context save/restore engine sitting on the other end of the general-purpose register file's ports.
//  SAVE reads every GPR through one read port and stores it to memory.
//  RESTORE loads words from memory and drives the GPR write port.
//  It is used by the exception/context-switch controller; busy stalls the CPU pipeline while a transfer runs.
// PARAMETERS
//  REG_NUM   32  number of GPRs transferred (indices 0..REG_NUM-1)
//  REG_AW    5   GPR address width, clog2(REG_NUM)
//  DATA_W    32  GPR / memory data width
//  MEM_AW    32  memory byte-address width
// PORTS
//  clk            in   1        clock
//  reset          in   1        reset, synchronous, active-high
//  start_save     in   1        1-cycle request: save all GPRs
//  start_restore  in   1        1-cycle request: restore all GPRs
//  base_addr      in   MEM_AW   context area byte address; sampled at accepted start
//  busy           out  1        transfer in progress (pipeline stall)
//  done           out  1        1-cycle pulse on completion
//  gpr_rd_addr    out  REG_AW   to GPR read port address
//  gpr_rd_data    in   DATA_W   from GPR read port; combinational read
//  gpr_we_        out  1        GPR write enable, active-low
//  gpr_wr_addr    out  REG_AW   GPR write address
//  gpr_wr_data    out  DATA_W   GPR write data
//  mem_req        out  1        memory request
//  mem_rw         out  1        1 = write (save), 0 = read (restore)
//  mem_addr       out  MEM_AW   word-aligned byte address
//  mem_wr_data    out  DATA_W   store data
//  mem_rd_data    in   DATA_W   load data; valid when mem_rdy=1
//  mem_rdy        in   1        handshake; a transfer completes at a posedge where mem_req & mem_rdy
// BEHAVIOUR
//  Reset values: busy=0, done=0, mem_req=0, mem_rw=0, mem_addr=0, gpr_we_=1, gpr_rd_addr=0, gpr_wr_addr=0.
//  Reset values, internal: idx=0, state=IDLE.
//  States: IDLE -> SAVE | RESTORE -> DONE -> IDLE.
//  IDLE:
//   - start_save=1: latch base_q={base_addr[MEM_AW-1:2],2'b00}, idx=0, go to SAVE.
//   - start_restore=1 (start_save=0): same latch, go to RESTORE.
//   - Both starts high: SAVE wins; restore is dropped.
//   - Starts outside IDLE are ignored (not queued).
//  busy=1 in SAVE, RESTORE and DONE; it rises the cycle after the accepted start.
//  Address: mem_addr = base_q + {idx,2'b00}, truncated to MEM_AW (wraps modulo 2^MEM_AW).
//  SAVE:
//   - mem_req=1, mem_rw=1, gpr_rd_addr=idx, mem_wr_data=gpr_rd_data (combinational path).
//   - mem_addr and mem_wr_data are held stable while mem_rdy=0.
//   - On handshake: idx++. After handshake at idx=REG_NUM-1, go to DONE.
//  RESTORE:
//   - mem_req=1, mem_rw=0.
//   - gpr_we_ = !(mem_rdy), combinational; gpr_wr_addr=idx; gpr_wr_data=mem_rd_data.
//   - The GPR write therefore lands on the same edge as the handshake.
//   - On handshake: idx++. After the last index, go to DONE.
//   - gpr_we_=1 in every other state and whenever mem_rdy=0.
//  DONE: mem_req=0, done=1 for exactly one cycle, then IDLE with busy=0.
//  Latency with mem_rdy tied to 1: REG_NUM cycles of mem_req, done in cycle REG_NUM+1 after start.
//  Each mem_rdy=0 cycle adds one cycle. mem_rdy while mem_req=0 is ignored.
//  Reset mid-transfer: at the reset edge all outputs return to their reset values.
//  Reset mid-transfer: no further GPR write or memory request is issued and done is not pulsed.
//  Reset mid-transfer: GPRs already written keep their values.
//  idx must not wrap: for REG_NUM=2^REG_AW, the terminal check uses idx==REG_NUM-1, not overflow.
// TESTING
//  1 Save, mem_rdy=1, base 0x0000_0100, GPR[i]=0x1000+i -> 32 stores at 0x100..0x17C,
//    data 0x1000..0x101F, done 33 cycles after start.
//  2 Save with mem_rdy toggling 0/1 each cycle -> addr/data held during rdy=0; 32 stores in order;
//    done after 64 cycles.
//  3 Restore, mem_rd_data=0xA5A5_0000+idx, base 0x200 -> loads 0x200..0x27C; GPR[i]=0xA5A5_0000+i;
//    gpr_we_ low exactly 32 cycles.
//  4 start_save and start_restore same cycle -> save runs (mem_rw=1); no GPR write occurs.
//  5 start_restore pulsed during a save at idx=5 -> ignored; save completes, single done pulse.
//  6 reset asserted during restore at idx=10 -> next cycle busy=0, mem_req=0, gpr_we_=1;
//    GPR[0..9] hold restored values, GPR[10..31] unchanged.
//  7 base 0xFFFF_FFF0 save -> mem_addr wraps to 0x0000_0000 at idx=4.

Source files
------------

// File: rtl/gpr_ctx_xfer.sv
// Context save/restore engine: streams every GPR out to memory (SAVE) or
// back in from memory (RESTORE) through the register file's ports.
module gpr_ctx_xfer #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_AW  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_save,
    input  logic              start_restore,
    input  logic [MEM_AW-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] gpr_rd_addr,
    input  logic [DATA_W-1:0] gpr_rd_data,
    output logic              gpr_we_,
    output logic [REG_AW-1:0] gpr_wr_addr,
    output logic [DATA_W-1:0] gpr_wr_data,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rdy
);

    // state      | meaning
    // ST_IDLE    | waiting for start_save / start_restore
    // ST_SAVE    | reading GPR[idx], storing it to base_q + 4*idx
    // ST_RESTORE | loading base_q + 4*idx, writing GPR[idx]
    // ST_DONE    | one-cycle completion pulse, still busy
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAVE    = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [REG_AW-1:0] IDX_LAST  = REG_AW'(REG_NUM - 1);
    localparam logic [MEM_AW-1:0] ALIGN_MSK = ~MEM_AW'(3);

    logic [1:0]        state;
    logic [REG_AW-1:0] idx;
    logic [MEM_AW-1:0] base_q;
    logic [MEM_AW-1:0] word_offset;
    logic              in_save;
    logic              in_restore;
    logic              in_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            base_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_save) begin
                        state  <= ST_SAVE;
                        idx    <= '0;
                        base_q <= base_addr & ALIGN_MSK;
                    end else if (start_restore) begin
                        state  <= ST_RESTORE;
                        idx    <= '0;
                        base_q <= base_addr & ALIGN_MSK;
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    // Terminal compare on the last index rather than on wrap, so
                    // REG_NUM == 2**REG_AW still stops after REG_NUM words.
                    if (mem_rdy) begin
                        if (idx == IDX_LAST) begin
                            state <= ST_DONE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_save     = (state == ST_SAVE);
    assign in_restore  = (state == ST_RESTORE);
    assign in_xfer     = in_save | in_restore;
    assign word_offset = MEM_AW'({idx, 2'b00});

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Requests and GPR writes are masked while reset is high so that a reset
    // landing mid-transfer cannot complete one last handshake on its edge.
    assign mem_req     = in_xfer & ~reset;
    assign mem_rw      = in_save;
    assign mem_addr    = in_xfer ? (base_q + word_offset) : '0;
    assign mem_wr_data = in_save ? gpr_rd_data : '0;

    assign gpr_rd_addr = in_save ? idx : '0;
    assign gpr_we_     = ~(in_restore & mem_rdy & ~reset);
    assign gpr_wr_addr = in_restore ? idx : '0;
    assign gpr_wr_data = in_restore ? mem_rd_data : '0;

endmodule

// File: tb/tb_gpr_ctx_xfer.sv
// Bench for gpr_ctx_xfer: behavioural GPR/memory model plus per-cycle output
// comparison and directed/random save/restore transfers.
module tb_gpr_ctx_xfer;
    localparam int N = 32;
    localparam int M_IDLE = 0, M_SAVE = 1, M_RESTORE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_save = 1'b0;
    logic        start_restore = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, done, gpr_we_, mem_req, mem_rw;
    logic [4:0]  gpr_rd_addr, gpr_wr_addr;
    logic [31:0] gpr_rd_data, gpr_wr_data, mem_addr, mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rdy = 1'b0;

    always #5 clk = ~clk;

    gpr_ctx_xfer #(.REG_NUM(32), .REG_AW(5), .DATA_W(32), .MEM_AW(32)) dut (
        .clk(clk), .reset(reset), .start_save(start_save), .start_restore(start_restore),
        .base_addr(base_addr), .busy(busy), .done(done),
        .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data),
        .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
    );

    // environment: GPR file and memory seen by the DUT
    logic [31:0] gpr_file [N];
    logic [31:0] mem [logic [31:0]];
    always_comb gpr_rd_data = gpr_file[gpr_rd_addr];

    // reference model
    int          m_mode = M_IDLE;
    int          m_k = 0;
    logic [31:0] m_base = '0;
    logic [31:0] exp_gpr [N];
    logic [31:0] exp_mem [logic [31:0]];

    int cyc = 0, test_id = 0, end_id = 0, rdy_mode = 0;
    int start_cyc = 0, done_cyc = 0, done_cnt = 0, wr_cnt = 0;
    bit done_seen = 1'b0, end_req = 1'b0;
    int passed = 0, total = 0;
    logic m_act;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] m_addr();
        return m_base + 32'(m_k * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d test %0d)", name, act, exp, cyc, test_id);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("we_in_reset", 32'(gpr_we_), 32'd1);
        end else begin
            m_act = (m_mode == M_SAVE) || (m_mode == M_RESTORE);
            chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
            chk("done", 32'(done), 32'(m_mode == M_DONE));
            chk("mem_req", 32'(mem_req), 32'(m_act));
            chk("gpr_we_", 32'(gpr_we_), 32'(!(m_mode == M_RESTORE && mem_rdy)));
            if (m_act) begin
                chk("mem_rw", 32'(mem_rw), 32'(m_mode == M_SAVE));
                chk("mem_addr", mem_addr, m_addr());
            end
            if (m_mode == M_SAVE) begin
                chk("gpr_rd_addr", 32'(gpr_rd_addr), 32'(m_k));
                chk("mem_wr_data", mem_wr_data, exp_gpr[m_k]);
            end
            if (m_mode == M_RESTORE && mem_rdy) begin
                chk("gpr_wr_addr", 32'(gpr_wr_addr), 32'(m_k));
                chk("gpr_wr_data", gpr_wr_data, mem_lookup(m_addr()));
            end
            if (test_id == 1 && m_mode == M_SAVE && m_k == 0) begin
                chk("t1_addr_first", mem_addr, 32'h0000_0100);
                chk("t1_data_first", mem_wr_data, 32'h0000_1000);
            end
            if (test_id == 1 && m_mode == M_SAVE && m_k == 31) begin
                chk("t1_addr_last", mem_addr, 32'h0000_017C);
                chk("t1_data_last", mem_wr_data, 32'h0000_101F);
            end
            if (test_id == 7 && m_mode == M_SAVE && m_k == 4)
                chk("t7_addr_wrap", mem_addr, 32'h0000_0000);
        end
        if (end_req) begin
            case (end_id)
                0: begin
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_mem_req", 32'(mem_req), 32'd0);
                    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
                    chk("rst_mem_addr", mem_addr, 32'd0);
                    chk("rst_gpr_we_", 32'(gpr_we_), 32'd1);
                    chk("rst_rd_addr", 32'(gpr_rd_addr), 32'd0);
                    chk("rst_wr_addr", 32'(gpr_wr_addr), 32'd0);
                end
                1: begin
                    chk("t1_done_seen", 32'(done_seen), 32'd1);
                    chk("t1_latency", 32'(done_cyc - start_cyc), 32'd33);
                    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
                end
                2: begin
                    chk("t2_done_seen", 32'(done_seen), 32'd1);
                    chk("t2_done_pulses", 32'(done_cnt), 32'd1);
                    chk("t2_mem_word7", mem_lookup(32'h31C), 32'h0000_1007);
                end
                3: begin
                    chk("t3_done_seen", 32'(done_seen), 32'd1);
                    chk("t3_we_low_cycles", 32'(wr_cnt), 32'd32);
                    chk("t3_gpr0", gpr_file[0], 32'hA5A5_0000);
                    chk("t3_gpr31", gpr_file[31], 32'hA5A5_001F);
                end
                4: begin
                    chk("t4_done_seen", 32'(done_seen), 32'd1);
                    chk("t4_no_gpr_write", 32'(wr_cnt), 32'd0);
                    chk("t4_saved_word0", mem_lookup(32'h400), 32'hA5A5_0000);
                end
                5: begin
                    chk("t5_done_seen", 32'(done_seen), 32'd1);
                    chk("t5_done_pulses", 32'(done_cnt), 32'd1);
                    chk("t5_no_gpr_write", 32'(wr_cnt), 32'd0);
                end
                6: begin
                    chk("t6_no_done", 32'(done_cnt), 32'd0);
                    chk("t6_gpr9", gpr_file[9], 32'hA5A5_0009);
                    chk("t6_gpr10", gpr_file[10], 32'h0000_600A);
                    chk("t6_gpr31", gpr_file[31], 32'h0000_601F);
                    chk("t6_busy", 32'(busy), 32'd0);
                    chk("t6_mem_req", 32'(mem_req), 32'd0);
                end
                7: begin
                    chk("t7_done_seen", 32'(done_seen), 32'd1);
                    chk("t7_word_at_0", mem_lookup(32'h0), 32'hA5A5_0004);
                end
                8: chk("rand_done_seen", 32'(done_seen), 32'd1);
                default: begin
                    for (int i = 0; i < N; i++) chk("final_gpr", gpr_file[i], exp_gpr[i]);
                    foreach (exp_mem[a]) chk("final_mem", mem_lookup(a), exp_mem[a]);
                end
            endcase
        end
    end

    task automatic model_update();
        if (reset) begin
            m_mode = M_IDLE;
            m_k = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start_save || start_restore) begin
                        m_mode = start_save ? M_SAVE : M_RESTORE;
                        m_base = {base_addr[31:2], 2'b00};
                        m_k = 0;
                    end
                end
                M_SAVE, M_RESTORE: begin
                    if (mem_rdy) begin
                        if (m_mode == M_SAVE) exp_mem[m_addr()] = exp_gpr[m_k];
                        else exp_gpr[m_k] = mem_lookup(m_addr());
                        if (m_k == N - 1) begin
                            m_mode = M_DONE;
                            m_k = 0;
                        end else begin
                            m_k++;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (gpr_we_ === 1'b0) begin
            gpr_file[gpr_wr_addr] = gpr_wr_data;
            wr_cnt++;
        end
        if (mem_req && mem_rdy && mem_rw) mem[mem_addr] = mem_wr_data;
        model_update();
        #1;
        start_save = 1'b0;
        start_restore = 1'b0;
        case (rdy_mode)
            0: mem_rdy = 1'b1;
            1: mem_rdy = ~mem_rdy;
            default: mem_rdy = ($urandom_range(0, 3) != 0);
        endcase
        mem_rd_data = mem_lookup(mem_addr);
        if (done) begin
            done_seen = 1'b1;
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_xfer(input bit sv, input bit rs, input logic [31:0] b);
        base_addr = b;
        start_save = sv;
        start_restore = rs;
        start_cyc = cyc;
        done_seen = 1'b0;
        done_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_seen) break;
        end
        step();
    endtask

    task automatic end_check(input int id);
        end_id = id;
        end_req = 1'b1;
        @(negedge clk);
        #1 end_req = 1'b0;
    endtask

    task automatic preload(input logic [31:0] v);
        for (int i = 0; i < N; i++) begin
            gpr_file[i] = v + 32'(i);
            exp_gpr[i] = v + 32'(i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        preload(32'h1000);
        for (int i = 0; i < N; i++) mem[32'h200 + 32'(4 * i)] = 32'hA5A5_0000 + 32'(i);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        end_check(0);

        test_id = 1; start_xfer(1'b1, 1'b0, 32'h100); run_until_done(100); end_check(1);

        test_id = 2; rdy_mode = 1; mem_rdy = 1'b1;
        start_xfer(1'b1, 1'b0, 32'h300); run_until_done(200); end_check(2);
        rdy_mode = 0;

        test_id = 3; start_xfer(1'b0, 1'b1, 32'h200); run_until_done(100); end_check(3);

        test_id = 4; start_xfer(1'b1, 1'b1, 32'h400); run_until_done(100); end_check(4);

        test_id = 5; start_xfer(1'b1, 1'b0, 32'h500);
        for (int i = 0; i < 20 && !(m_mode == M_SAVE && m_k == 5); i++) step();
        start_restore = 1'b1;
        run_until_done(100); end_check(5);

        test_id = 6; preload(32'h6000); start_xfer(1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 20 && !(m_mode == M_RESTORE && m_k == 10); i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        end_check(6);

        test_id = 7; start_xfer(1'b1, 1'b0, 32'hFFFF_FFF0); run_until_done(100); end_check(7);

        test_id = 8; rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            automatic bit sv = 1'($urandom_range(0, 1));
            start_xfer(sv, !sv, $urandom);
            for (int i = 0; i < 300; i++) begin
                step();
                if (done_seen) break;
                if (m_mode != M_IDLE && m_mode != M_DONE && $urandom_range(0, 15) == 0) begin
                    start_save = 1'($urandom_range(0, 1));
                    start_restore = 1'b1;
                    base_addr = $urandom;
                end
            end
            step();
            end_check(8);
        end

        test_id = 99;
        end_check(99);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
